// File: rtl/des_sbox_engine.sv
// DES S-box substitution engine: one 48-bit keyed round word in, 32-bit S1..S8 result out.
// LANES boxes are looked up per cycle, so a word takes 8/LANES busy cycles.
module des_sbox_engine #(
   parameter int LANES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [47:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);

   // Handshake: a word moves on a rising edge where valid && ready are both high.
   // in_ready depends only on state and out_ready, never on in_valid.

   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
         $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
      end
   endgenerate

   localparam logic [2:0] LAST_IDX = 3'(8 - LANES);
   localparam logic [2:0] IDX_STEP = 3'(LANES);

   // One 256-bit row-major table per box; entry i = {row, column} sits at nibble 63-i.
   localparam logic [255:0] SBOX [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [47:0] hold;
   logic [31:0] result;
   logic [2:0]  idx;
   logic        accept;
   logic        last;

   logic [2:0]  lane_box   [LANES];
   logic [5:0]  lane_chunk [LANES];
   logic [5:0]  lane_addr  [LANES];
   logic [3:0]  lane_nib   [LANES];

   assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
   assign accept    = in_valid && in_ready;
   assign last      = (idx == LAST_IDX);
   assign out_valid = (state == DONE);
   assign busy      = (state == BUSY);
   assign out_data  = result;

   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         lane_box[j]   = idx + 3'(j);
         lane_chunk[j] = hold[int'(3'd7 - lane_box[j]) * 6 +: 6];
         lane_addr[j]  = {lane_chunk[j][5], lane_chunk[j][0], lane_chunk[j][4:1]};
         lane_nib[j]   = SBOX[lane_box[j]][{~lane_addr[j], 2'b00} +: 4];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = BUSY;
         BUSY:    if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // The final busy cycle leaves idx in place so it never steps past S8.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold   <= '0;
         result <= '0;
         idx    <= '0;
      end else if (accept) begin
         hold <= in_data;
         idx  <= '0;
      end else if (state == BUSY) begin
         for (int j = 0; j < LANES; j++) begin
            result[{3'd7 - lane_box[j], 2'b00} +: 4] <= lane_nib[j];
         end
         if (!last) idx <= idx + IDX_STEP;
      end
   end

endmodule

// File: tb/tb_des_sbox_engine.sv
// Bench for des_sbox_engine: one instance per legal LANES value (1, 2, 4, 8),
// checked against a table-driven DES substitution model.
module tb_des_sbox_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid  [4];
   logic        in_ready  [4];
   logic [47:0] in_data   [4];
   logic        out_valid [4];
   logic        out_ready [4];
   logic [31:0] out_data  [4];
   logic        busy      [4];

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q [$];

   // Reference tables, row-major, first entry in the most significant nibble.
   localparam logic [255:0] REF_TAB [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
   };

   generate
      for (genvar g = 0; g < 4; g++) begin : g_dut
         des_sbox_engine #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
         );
      end
   endgenerate

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] sbox_ref(input logic [47:0] w);
      logic [31:0] r;
      int c, row, col, pos;
      r = '0;
      for (int b = 0; b < 8; b++) begin
         c   = int'((w >> (42 - 6 * b)) & 48'h3f);
         row = (c / 32) * 2 + (c % 2);
         col = (c / 2) % 16;
         pos = row * 16 + col;
         r   = r | (32'((REF_TAB[b] >> (4 * (63 - pos))) & 256'hf) << (28 - 4 * b));
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Called just after an edge that moved the DUT into BUSY; counts edges up to out_valid.
   task automatic wait_done(input int g, output int lat, output int bc);
      lat = 0;
      bc  = 0;
      while (!out_valid[g] && lat < 20) begin
         if (busy[g]) bc++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_word(input int g, input logic [47:0] d, input int stall,
                           output logic [31:0] res);
      int lat, bc;
      logic [31:0] expv;
      check("idle_ready", 32'(in_ready[g]), 32'd1);
      in_valid[g] = 1'b1;
      in_data[g]  = d;
      exp_q.push_back(sbox_ref(d));
      @(posedge clk); #1;
      in_valid[g] = 1'b0;
      in_data[g]  = {16'($urandom), $urandom};
      check("busy_not_ready", 32'(in_ready[g]), 32'd0);
      wait_done(g, lat, bc);
      check("latency", lat, 8 >> g);
      check("busy_cycles", bc, 8 >> g);
      expv = exp_q.pop_front();
      res  = out_data[g];
      check("result", res, expv);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         check("stall_valid", 32'(out_valid[g]), 32'd1);
         check("stall_data", out_data[g], expv);
         check("stall_ready", 32'(in_ready[g]), 32'd0);
      end
      out_ready[g] = 1'b1;
      #1;
      check("ready_from_out_ready", 32'(in_ready[g]), 32'd1);
      @(posedge clk); #1;
      out_ready[g] = 1'b0;
      check("valid_drop", 32'(out_valid[g]), 32'd0);
      check("idle_not_busy", 32'(busy[g]), 32'd0);
   endtask

   initial begin
      logic [31:0] res;
      logic [47:0] d;
      logic [3:0]  s8_exp [4];
      logic [5:0]  s8_in  [4];
      int lat, bc, cyc, n_got, first_c, g;

      s8_in  = '{6'b000000, 6'b000001, 6'b100000, 6'b111111};
      s8_exp = '{4'd13, 4'd1, 4'd7, 4'd11};

      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid[i]  = 1'b0;
         in_data[i]   = '0;
         out_ready[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         check("rst_in_ready", 32'(in_ready[i]), 32'd1);
         check("rst_out_valid", 32'(out_valid[i]), 32'd0);
         check("rst_busy", 32'(busy[i]), 32'd0);
         check("rst_out_data", out_data[i], 32'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Zero and all-ones words on every lane count.
      for (int i = 0; i < 4; i++) begin
         run_word(i, 48'h0, 0, res);
         check("zero_word", res, 32'hEFA72C4D);
         run_word(i, 48'hFFFFFFFFFFFF, 1, res);
         check("ones_word", res, 32'hD9CE3DCB);
      end

      // S8 row/column corners.
      for (int i = 0; i < 4; i++) begin
         run_word(1, {42'h0, s8_in[i]}, 0, res);
         check("s8_low", 32'(res[3:0]), 32'(s8_exp[i]));
         check("s8_high", 32'(res[31:4]), 32'h0EFA72C4);
      end

      // Backpressure with a second word waiting, then the DONE->BUSY handoff.
      in_valid[1] = 1'b1;
      in_data[1]  = 48'h0;
      @(posedge clk); #1;
      in_data[1] = 48'hFFFFFFFFFFFF;
      wait_done(1, lat, bc);
      check("bp_latency", lat, 4);
      repeat (10) begin
         @(posedge clk); #1;
         check("bp_valid", 32'(out_valid[1]), 32'd1);
         check("bp_data", out_data[1], sbox_ref(48'h0));
         check("bp_ready", 32'(in_ready[1]), 32'd0);
         check("bp_no_accept", 32'(busy[1]), 32'd0);
      end
      out_ready[1] = 1'b1;
      @(posedge clk); #1;
      out_ready[1] = 1'b0;
      in_valid[1]  = 1'b0;
      check("handoff_valid_drop", 32'(out_valid[1]), 32'd0);
      check("handoff_captured", 32'(busy[1]), 32'd1);
      wait_done(1, lat, bc);
      check("handoff_latency", lat, 4);
      check("handoff_data", out_data[1], sbox_ref(48'hFFFFFFFFFFFF));
      out_ready[1] = 1'b1;
      @(posedge clk); #1;
      out_ready[1] = 1'b0;

      // Back-to-back streaming on LANES=4.
      in_valid[2]  = 1'b1;
      in_data[2]   = 48'h0;
      out_ready[2] = 1'b1;
      exp_q.push_back(sbox_ref(48'h0));
      exp_q.push_back(sbox_ref(48'hFFFFFFFFFFFF));
      @(posedge clk); #1;
      in_data[2] = 48'hFFFFFFFFFFFF;
      cyc = 0; n_got = 0; first_c = 0;
      while (n_got < 2 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (n_got == 1 && cyc > first_c) in_valid[2] = 1'b0;
         if (out_valid[2]) begin
            check("b2b_data", out_data[2], exp_q.pop_front());
            if (n_got == 0) first_c = cyc;
            else check("b2b_spacing", cyc - first_c, 3);
            n_got++;
         end
      end
      check("b2b_count", n_got, 2);
      check("b2b_first_latency", first_c, 2);
      @(posedge clk); #1;
      out_ready[2] = 1'b0;
      check("b2b_drain", 32'(out_valid[2]), 32'd0);
      exp_q.delete();

      // Asynchronous reset between edges during BUSY on LANES=1.
      in_valid[0] = 1'b1;
      in_data[0]  = 48'hFFFFFFFFFFFF;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #4;
      rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid[0]), 32'd0);
      check("arst_busy", 32'(busy[0]), 32'd0);
      check("arst_out_data", out_data[0], 32'd0);
      check("arst_in_ready", 32'(in_ready[0]), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("arst_no_stale_valid", 32'(out_valid[0]), 32'd0);
      run_word(0, 48'h0, 0, res);
      check("arst_fresh_word", res, 32'hEFA72C4D);

      // Random words across lane counts with random output stalls.
      repeat (24) begin
         g = $urandom_range(0, 3);
         d = {16'($urandom), $urandom};
         run_word(g, d, $urandom_range(0, 3), res);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
